trace_checker: RTL and testbench

TRACE_CHECKER -- requirements
Module: trace_checker

---
 rtl/trace_pkg.sv | 30 +++
 rtl/trace_checker_if.sv | 44 ++++
 rtl/trace_compare.sv | 30 +++
 rtl/trace_checker.sv | 134 +++++++++++++
 tb/tb_trace_checker.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared types for the retire-trace checker: verdict states, fail codes and
// the layout of one golden/observed trace entry.
package trace_pkg;

    localparam int PC_W   = 32;
    localparam int REG_W  = 5;
    localparam int VAL_W  = 32;
    localparam int CODE_W = 2;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

    typedef logic [CODE_W-1:0] fail_code_t;

    localparam fail_code_t FC_NONE    = 2'd0;
    localparam fail_code_t FC_PC      = 2'd1;
    localparam fail_code_t FC_WB      = 2'd2;
    localparam fail_code_t FC_TIMEOUT = 2'd3;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             ena;
        logic [REG_W-1:0] rd;
        logic [VAL_W-1:0] value;
    } trace_entry_t;

endpackage

// File: rtl/trace_checker_if.sv
// Bundle between the checker, the CPU writeback debug port and the golden
// trace memory. master = environment side, slave = checker side.
interface trace_checker_if
    import trace_pkg::*;
#(
    parameter int ADDR_W = 16
) ();

    logic              debug_wb_have_inst;
    logic [PC_W-1:0]   debug_wb_pc;
    logic              debug_wb_ena;
    logic [REG_W-1:0]  debug_wb_reg;
    logic [VAL_W-1:0]  debug_wb_value;

    logic [ADDR_W-1:0] gold_addr;
    logic              gold_valid;
    logic [PC_W-1:0]   gold_pc;
    logic              gold_ena;
    logic [REG_W-1:0]  gold_reg;
    logic [VAL_W-1:0]  gold_value;

    logic              pass;
    logic              fail;
    logic [CODE_W-1:0] fail_code;
    logic [31:0]       err_pc;
    logic [31:0]       err_exp;
    logic [31:0]       err_got;
    logic [31:0]       inst_count;

    modport master (
        output debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value,
        output gold_valid, gold_pc, gold_ena, gold_reg, gold_value,
        input  gold_addr,
        input  pass, fail, fail_code, err_pc, err_exp, err_got, inst_count
    );

    modport slave (
        input  debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value,
        input  gold_valid, gold_pc, gold_ena, gold_reg, gold_value,
        output gold_addr,
        output pass, fail, fail_code, err_pc, err_exp, err_got, inst_count
    );

endinterface

// File: rtl/trace_compare.sv
// Combinational comparison of one retired instruction against its golden
// entry; yields a match flag and the fail code a mismatch would report.
module trace_compare
    import trace_pkg::*;
(
    input  trace_entry_t got,
    input  trace_entry_t exp,
    output logic         match,
    output fail_code_t   code
);

    logic pc_ok;
    logic ena_ok;
    logic rd_ok;
    logic val_ok;

    always_comb begin
        pc_ok  = (got.pc == exp.pc);
        ena_ok = (got.ena == exp.ena);
        rd_ok  = !exp.ena || (got.rd == exp.rd);
        // Writes to x0 are discarded by the CPU, so their data is don't-care.
        val_ok = !exp.ena || (exp.rd == '0) || (got.value == exp.value);
        match  = pc_ok && ena_ok && rd_ok && val_ok;
        code   = FC_NONE;
        if (!match) begin
            code = pc_ok ? FC_WB : FC_PC;
        end
    end

endmodule

// File: rtl/trace_checker.sv
// Lock-step checker of a CPU retire stream against a golden trace, with an
// idle watchdog and a sticky pass/fail verdict plus diagnostics.
module trace_checker
    import trace_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    trace_checker_if.slave  bus
);

    localparam int IDLE_W = $clog2(TIMEOUT) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 2);

    state_e            state_q,      state_d;
    logic [ADDR_W-1:0] gold_addr_q,  gold_addr_d;
    logic [31:0]       inst_count_q, inst_count_d;
    logic [IDLE_W-1:0] idle_q,       idle_d;
    logic [PC_W-1:0]   last_pc_q,    last_pc_d;
    logic              pass_q,       pass_d;
    logic              fail_q,       fail_d;
    fail_code_t        fail_code_q,  fail_code_d;
    logic [31:0]       err_pc_q,     err_pc_d;
    logic [31:0]       err_exp_q,    err_exp_d;
    logic [31:0]       err_got_q,    err_got_d;

    trace_entry_t got_entry;
    trace_entry_t exp_entry;
    logic         match;
    fail_code_t   cmp_code;

    assign got_entry = {bus.debug_wb_pc, bus.debug_wb_ena, bus.debug_wb_reg, bus.debug_wb_value};
    assign exp_entry = {bus.gold_pc, bus.gold_ena, bus.gold_reg, bus.gold_value};

    trace_compare u_cmp (
        .got   (got_entry),
        .exp   (exp_entry),
        .match (match),
        .code  (cmp_code)
    );

    always_comb begin
        state_d      = state_q;
        gold_addr_d  = gold_addr_q;
        inst_count_d = inst_count_q;
        idle_d       = idle_q;
        last_pc_d    = last_pc_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        fail_code_d  = fail_code_q;
        err_pc_d     = err_pc_q;
        err_exp_d    = err_exp_q;
        err_got_d    = err_got_q;

        case (state_q)
            ST_RUN: begin
                // End of trace wins over a retire in the same cycle.
                if (!bus.gold_valid) begin
                    state_d = ST_PASS;
                    pass_d  = 1'b1;
                end else if (bus.debug_wb_have_inst) begin
                    idle_d = '0;
                    if (match) begin
                        gold_addr_d  = gold_addr_q + 1'b1;
                        inst_count_d = inst_count_q + 32'd1;
                        last_pc_d    = bus.debug_wb_pc;
                    end else begin
                        state_d     = ST_FAIL;
                        fail_d      = 1'b1;
                        fail_code_d = cmp_code;
                        err_pc_d    = bus.debug_wb_pc;
                        if (cmp_code == FC_PC) begin
                            err_exp_d = bus.gold_pc;
                            err_got_d = bus.debug_wb_pc;
                        end else begin
                            err_exp_d = bus.gold_value;
                            err_got_d = bus.debug_wb_value;
                        end
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d     = ST_FAIL;
                    fail_d      = 1'b1;
                    fail_code_d = FC_TIMEOUT;
                    err_pc_d    = last_pc_q;
                    err_exp_d   = '0;
                    err_got_d   = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            gold_addr_q  <= '0;
            inst_count_q <= '0;
            idle_q       <= '0;
            last_pc_q    <= '0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_code_q  <= FC_NONE;
            err_pc_q     <= '0;
            err_exp_q    <= '0;
            err_got_q    <= '0;
        end else begin
            state_q      <= state_d;
            gold_addr_q  <= gold_addr_d;
            inst_count_q <= inst_count_d;
            idle_q       <= idle_d;
            last_pc_q    <= last_pc_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            fail_code_q  <= fail_code_d;
            err_pc_q     <= err_pc_d;
            err_exp_q    <= err_exp_d;
            err_got_q    <= err_got_d;
        end
    end

    assign bus.gold_addr  = gold_addr_q;
    assign bus.inst_count = inst_count_q;
    assign bus.pass       = pass_q;
    assign bus.fail       = fail_q;
    assign bus.fail_code  = fail_code_q;
    assign bus.err_pc     = err_pc_q;
    assign bus.err_exp    = err_exp_q;
    assign bus.err_got    = err_got_q;

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker: single-retire vector table, directed multi-cycle
// sequences, and randomized traces checked each cycle against a trace model.
module tb_trace_checker;
    import trace_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trace_checker_if #(.ADDR_W(ADDR_W)) bus ();

    trace_checker #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    trace_entry_t mem [DEPTH];
    bit           mem_valid [DEPTH];

    // Golden memory, read combinationally at gold_addr.
    always_comb begin
        bus.gold_valid = 1'b0;
        bus.gold_pc    = '0;
        bus.gold_ena   = 1'b0;
        bus.gold_reg   = '0;
        bus.gold_value = '0;
        if (int'(bus.gold_addr) < DEPTH) begin
            bus.gold_valid = mem_valid[bus.gold_addr[5:0]];
            bus.gold_pc    = mem[bus.gold_addr[5:0]].pc;
            bus.gold_ena   = mem[bus.gold_addr[5:0]].ena;
            bus.gold_reg   = mem[bus.gold_addr[5:0]].rd;
            bus.gold_value = mem[bus.gold_addr[5:0]].value;
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model: verdict derived from trace position and elapsed cycles.
    int          m_state;   // 0 running, 1 passed, 2 failed
    int unsigned m_count;
    int          m_cyc;
    int          m_last_ret;
    logic [31:0] m_last_pc, m_err_pc, m_exp, m_got;
    int          m_code;

    function automatic trace_entry_t mk(logic [31:0] pc, logic ena, logic [4:0] rd, logic [31:0] val);
        trace_entry_t e;
        e.pc = pc; e.ena = ena; e.rd = rd; e.value = val;
        return e;
    endfunction

    function automatic bit rule_match(trace_entry_t g, trace_entry_t d);
        if (g.pc != d.pc) return 1'b0;
        if (g.ena != d.ena) return 1'b0;
        if (g.ena && g.rd != d.rd) return 1'b0;
        if (g.ena && g.rd != 5'd0 && g.value != d.value) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_count = 0; m_cyc = 0; m_last_ret = 0;
        m_last_pc = '0; m_err_pc = '0; m_exp = '0; m_got = '0; m_code = 0;
    endtask

    task automatic model_edge(input bit have, input trace_entry_t d);
        int idx;
        m_cyc++;
        if (m_state != 0) return;
        idx = int'(m_count % (1 << ADDR_W));
        if (idx >= DEPTH || !mem_valid[idx]) begin
            m_state = 1;
        end else if (have) begin
            m_last_ret = m_cyc;
            if (rule_match(mem[idx], d)) begin
                m_count++;
                m_last_pc = d.pc;
            end else begin
                m_state  = 2;
                m_err_pc = d.pc;
                if (d.pc != mem[idx].pc) begin
                    m_code = 1; m_exp = mem[idx].pc; m_got = d.pc;
                end else begin
                    m_code = 2; m_exp = mem[idx].value; m_got = d.value;
                end
            end
        end else if (m_cyc - m_last_ret == TIMEOUT - 1) begin
            m_state = 2; m_code = 3; m_err_pc = m_last_pc; m_exp = '0; m_got = '0;
        end
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".pass"},       32'(bus.pass),      32'(m_state == 1));
        check_eq({tag, ".fail"},       32'(bus.fail),      32'(m_state == 2));
        check_eq({tag, ".fail_code"},  32'(bus.fail_code), 32'(m_code));
        check_eq({tag, ".inst_count"}, bus.inst_count,     32'(m_count));
        check_eq({tag, ".gold_addr"},  32'(bus.gold_addr), 32'(m_count % (1 << ADDR_W)));
        check_eq({tag, ".err_pc"},     bus.err_pc,         m_err_pc);
        check_eq({tag, ".err_exp"},    bus.err_exp,        m_exp);
        check_eq({tag, ".err_got"},    bus.err_got,        m_got);
    endtask

    task automatic step(input bit have, input trace_entry_t d);
        bus.debug_wb_have_inst = have;
        bus.debug_wb_pc        = d.pc;
        bus.debug_wb_ena       = d.ena;
        bus.debug_wb_reg       = d.rd;
        bus.debug_wb_value     = d.value;
        @(posedge clk);
        model_edge(have, d);
        #1;
    endtask

    task automatic do_reset();
        bus.debug_wb_have_inst = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            mem_valid[i] = 1'b0;
        end
    endtask

    task automatic load3();
        clear_mem();
        mem[0] = mk(32'h0, 1'b1, 5'd1, 32'h11); mem_valid[0] = 1'b1;
        mem[1] = mk(32'h4, 1'b1, 5'd2, 32'h22); mem_valid[1] = 1'b1;
        mem[2] = mk(32'h8, 1'b0, 5'd0, 32'h0);  mem_valid[2] = 1'b1;
    endtask

    typedef struct {
        trace_entry_t g;
        trace_entry_t d;
        int           code;
        logic [31:0]  eexp;
        logic [31:0]  egot;
    } vec_t;

    vec_t vt [10];

    function automatic vec_t mkv(trace_entry_t g, trace_entry_t d, int code, logic [31:0] e, logic [31:0] o);
        vec_t v;
        v.g = g; v.d = d; v.code = code; v.eexp = e; v.egot = o;
        return v;
    endfunction

    trace_entry_t idle_e;

    initial begin
        idle_e = '0;
        bus.debug_wb_have_inst = 1'b0;
        bus.debug_wb_pc = '0; bus.debug_wb_ena = 1'b0;
        bus.debug_wb_reg = '0; bus.debug_wb_value = '0;

        vt[0] = mkv(mk(32'h100, 1, 5, 32'h55),   mk(32'h100, 1, 5, 32'h55),   0, 0, 0);
        vt[1] = mkv(mk(32'h4,   1, 3, 32'h7),    mk(32'h8,   1, 3, 32'h7),    1, 32'h4, 32'h8);
        vt[2] = mkv(mk(32'h20,  1, 5, 32'h13),   mk(32'h20,  1, 5, 32'h12),   2, 32'h13, 32'h12);
        vt[3] = mkv(mk(32'h24,  1, 0, 32'h0),    mk(32'h24,  1, 0, 32'hDEAD), 0, 0, 0);
        vt[4] = mkv(mk(32'h28,  1, 2, 32'h9),    mk(32'h28,  0, 2, 32'h9),    2, 32'h9, 32'h9);
        vt[5] = mkv(mk(32'h2C,  1, 0, 32'h0),    mk(32'h2C,  1, 3, 32'h0),    2, 0, 0);
        vt[6] = mkv(mk(32'h30,  0, 7, 32'h1),    mk(32'h30,  0, 9, 32'h2),    0, 0, 0);
        vt[7] = mkv(mk(32'h34,  1, 1, 32'hAA),   mk(32'h38,  1, 1, 32'hBB),   1, 32'h34, 32'h38);
        vt[8] = mkv(mk(32'h3C,  1, 5, 32'h77),   mk(32'h3C,  1, 6, 32'h77),   2, 32'h77, 32'h77);
        vt[9] = mkv(mk(32'h40,  0, 0, 32'h0),    mk(32'h40,  1, 0, 32'h0),    2, 0, 0);

        // Single-retire table against a one-entry trace.
        for (int v = 0; v < 10; v++) begin
            clear_mem();
            mem[0] = vt[v].g; mem_valid[0] = 1'b1;
            do_reset();
            step(1'b1, vt[v].d);
            check_eq($sformatf("vec%0d.fail", v),       32'(bus.fail),      32'(vt[v].code != 0));
            check_eq($sformatf("vec%0d.fail_code", v),  32'(bus.fail_code), 32'(vt[v].code));
            check_eq($sformatf("vec%0d.inst_count", v), bus.inst_count,     32'(vt[v].code == 0));
            check_eq($sformatf("vec%0d.err_exp", v),    bus.err_exp,        vt[v].eexp);
            check_eq($sformatf("vec%0d.err_got", v),    bus.err_got,        vt[v].egot);
            check_eq($sformatf("vec%0d.err_pc", v),     bus.err_pc,         (vt[v].code != 0) ? vt[v].d.pc : 32'h0);
            step(1'b0, idle_e);
            check_eq($sformatf("vec%0d.pass", v),       32'(bus.pass),      32'(vt[v].code == 0));
            $display("vec %0d: pc=0x%08h code=%0d count=%0d pass=%0d", v, vt[v].d.pc,
                     bus.fail_code, bus.inst_count, bus.pass);
        end

        // Three back-to-back matches then the terminator.
        load3();
        do_reset();
        check_eq("reset.gold_addr", 32'(bus.gold_addr), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, mem[i]);
        check_eq("b2b.count3", bus.inst_count, 32'd3);
        check_eq("b2b.pass_early", 32'(bus.pass), 32'd0);
        step(1'b0, idle_e);
        check_eq("b2b.pass", 32'(bus.pass), 32'd1);
        check_eq("b2b.fail", 32'(bus.fail), 32'd0);
        step(1'b1, mem[0]);
        check_eq("b2b.frozen_count", bus.inst_count, 32'd3);
        $display("seq b2b: count=%0d pass=%0d", bus.inst_count, bus.pass);

        // Wrong pc on the second retire; verdict must then freeze.
        load3();
        do_reset();
        step(1'b1, mem[0]);
        step(1'b1, mk(32'h8, 1'b1, 5'd2, 32'h22));
        check_eq("pcerr.fail", 32'(bus.fail), 32'd1);
        check_eq("pcerr.code", 32'(bus.fail_code), 32'd1);
        check_eq("pcerr.exp", bus.err_exp, 32'h4);
        check_eq("pcerr.got", bus.err_got, 32'h8);
        check_eq("pcerr.count", bus.inst_count, 32'd1);
        step(1'b1, mk(32'h99, 1'b1, 5'd7, 32'h5));
        check_eq("pcerr.frozen_got", bus.err_got, 32'h8);
        $display("seq pcerr: code=%0d exp=0x%08h got=0x%08h", bus.fail_code, bus.err_exp, bus.err_got);

        // Watchdog: fires exactly TIMEOUT-1 cycles after the last retire.
        load3();
        do_reset();
        step(1'b1, mem[0]);
        for (int i = 0; i < TIMEOUT - 2; i++) step(1'b0, idle_e);
        check_eq("tmo.not_yet", 32'(bus.fail), 32'd0);
        step(1'b0, idle_e);
        check_eq("tmo.fail", 32'(bus.fail), 32'd1);
        check_eq("tmo.code", 32'(bus.fail_code), 32'd3);
        check_eq("tmo.err_pc", bus.err_pc, mem[0].pc);
        check_eq("tmo.err_exp", bus.err_exp, 32'h0);
        $display("seq timeout: code=%0d err_pc=0x%08h", bus.fail_code, bus.err_pc);

        // Reset after a failure verdict, then a clean run.
        do_reset();
        check_eq("rerun.fail", 32'(bus.fail), 32'd0);
        check_eq("rerun.code", 32'(bus.fail_code), 32'd0);
        check_eq("rerun.err_pc", bus.err_pc, 32'd0);
        check_eq("rerun.count", bus.inst_count, 32'd0);
        check_eq("rerun.gold_addr", 32'(bus.gold_addr), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, mem[i]);
        step(1'b0, idle_e);
        check_eq("rerun.pass", 32'(bus.pass), 32'd1);
        $display("seq rerun: pass=%0d count=%0d", bus.pass, bus.inst_count);

        // Randomized traces against the model, compared every cycle.
        for (int s = 0; s < 40; s++) begin
            int  n, stall_at, post, cyc;
            bit  stall, have;
            trace_entry_t d;
            n = $urandom_range(0, 10);
            stall = (s % 4 == 3);
            stall_at = $urandom_range(0, n);
            clear_mem();
            for (int i = 0; i < n; i++) begin
                mem[i] = mk($urandom, 1'($urandom), ($urandom % 3 == 0) ? 5'd0 : 5'($urandom), $urandom);
                mem_valid[i] = 1'b1;
            end
            do_reset();
            check_model("rnd.reset");
            post = 0;
            for (cyc = 0; cyc < 200; cyc++) begin
                if (m_state != 0) begin
                    if (post >= 2) break;
                    post++;
                end
                if (m_state == 0 && stall && int'(m_count) >= stall_at) have = 1'b0;
                else if (m_state == 0) have = ($urandom % 4 != 0);
                else have = 1'($urandom);
                if (m_count < DEPTH && mem_valid[m_count]) d = mem[m_count];
                else d = mk($urandom, 1'($urandom), 5'($urandom), $urandom);
                if ($urandom % 10 == 0) begin
                    case ($urandom_range(0, 3))
                        0: d.pc    = d.pc ^ (32'h1 << $urandom_range(0, 31));
                        1: d.ena   = ~d.ena;
                        2: d.rd    = d.rd ^ 5'(1 << $urandom_range(0, 4));
                        default: d.value = d.value ^ (32'h1 << $urandom_range(0, 31));
                    endcase
                end
                step(have, d);
                check_model($sformatf("rnd%0d.c%0d", s, cyc));
            end
            total++;
            if (m_state == 0) begin
                bad++;
                $display("FAIL rnd%0d.bound: no verdict within 200 cycles, required one", s);
            end
            $display("rnd %0d: len=%0d verdict=%0d code=%0d count=%0d", s, n, m_state, bus.fail_code, bus.inst_count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
